uart_capture: RTL and testbench

UART_CAPTURE -- requirements
Module: uart_capture

---
 rtl/uart_capture_pkg.sv | 23 ++
 rtl/uart_capture_fifo.sv | 55 +++++
 rtl/uart_capture.sv | 173 +++++++++++++++++
 tb/tb_uart_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_capture_pkg.sv
// Shared receiver types and helpers for uart_capture.
// The PARITY state exists only when UART_CAPTURE_PARITY_EN is defined.
package uart_capture_pkg;

  localparam int unsigned CPB_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_CAPTURE_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned clocks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_capture_fifo.sv
// First-word-fall-through capture FIFO; pointers wrap modulo DEPTH (power of two).
module uart_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_capture.sv
// UART receiver feeding a capture FIFO, with sticky frame/parity/overflow flags.
// Optional parity bit enabled by defining UART_CAPTURE_PARITY_EN.
module uart_capture
  import uart_capture_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 10_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overflow,
  input  logic                   err_clear
);

  localparam int unsigned CPB  = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB) + 1;
  localparam int unsigned BW   = $clog2(DATA_BITS) + 1;

  if (CPB < CPB_MIN) begin : g_cpb_chk
    $fatal(1, "uart_capture: clocks per bit below CPB_MIN");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $fatal(1, "uart_capture: DATA_BITS outside 5..9");
  end
  if (PARITY_ODD > 1) begin : g_par_chk
    $fatal(1, "uart_capture: PARITY_ODD must be 0 or 1");
  end

  logic                 r_sync1, r_sync2, r_prev;
  logic                 w_line;
  rx_state_e            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_push, w_pop, w_full, w_empty;
  logic                 w_frame_set, w_ovf_set, w_par_set;
  logic                 r_frame_err, r_overflow;

  assign w_line = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    w_par_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The detection cycle is cycle 0 of the start bit.
        w_cnt_nxt = CW'(1);
        if (r_prev && !w_line) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == CW'(HALF)) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CW'(CPB - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit + BW'(1);
          if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_CAPTURE_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_CAPTURE_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == CW'(CPB - 1)) begin
          w_cnt_nxt   = '0;
          w_par_set   = ((^r_shift) ^ w_line) != 1'(PARITY_ODD);
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == CW'(CPB - 1)) begin
          w_cnt_nxt = '0;
          if (w_line) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (!w_line) w_cnt_nxt = '0;
        else if (r_cnt == CW'(CPB - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pop     = data_out_valid & data_out_ready;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1     <= serial_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_set | (r_frame_err & ~err_clear);
      r_overflow  <= w_ovf_set   | (r_overflow  & ~err_clear);
    end
  end

`ifdef UART_CAPTURE_PARITY_EN
  logic r_parity_err;
  always_ff @(posedge clk) begin
    if (rst) r_parity_err <= 1'b0;
    else     r_parity_err <= w_par_set | (r_parity_err & ~err_clear);
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = w_par_set;
`endif

  assign frame_err      = r_frame_err;
  assign overflow       = r_overflow;
  assign data_out_valid = ~w_empty;

  uart_capture_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (r_shift),
    .i_pop     (w_pop),
    .o_rd_data (data_out),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (count)
  );

endmodule

// File: tb/tb_uart_capture.sv
// Scoreboard bench for uart_capture (50 MHz / 10 Mbaud, CPB = 5, DEPTH = 16).
// Parity case runs only when UART_CAPTURE_PARITY_EN is defined.
module tb_uart_capture;

  localparam int unsigned CPB   = 5;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [4:0] count;
  logic       frame_err, parity_err, overflow, err_clear;

  int n_cmp = 0;
  int n_err = 0;
  int n_rx  = 0;
  int max_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_capture #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (10_000_000),
    .DATA_BITS  (8),
    .DEPTH      (DEPTH),
    .PARITY_ODD (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .count          (count),
    .frame_err      (frame_err),
    .parity_err     (parity_err),
    .overflow       (overflow),
    .err_clear      (err_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample mid-cycle, a handshake completes at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
      else begin
        check("rx_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        n_rx++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_body(input logic [7:0] d);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_CAPTURE_PARITY_EN
    serial_in = ^d;
    repeat (CPB) @(negedge clk);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input bit expect_it);
    if (expect_it) exp_q.push_back(d);
    send_body(d);
    serial_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({"drain_", tag}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int rx0;
    rst = 1'b1; serial_in = 1'b1; data_out_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame, consumer stalled; valid rises the cycle after the stop sample.
    exp_q.push_back(8'h4F);
    send_body(8'h4F);
    serial_in = 1'b1;
    repeat (CPB - 1) @(negedge clk);
    check("4f_valid_at_sample", {31'd0, data_out_valid}, 32'd0);
    @(negedge clk);
    check("4f_valid", {31'd0, data_out_valid}, 32'd1);
    check("4f_count", {27'd0, count}, 32'd1);
    check("4f_data", {24'd0, data_out}, 32'h4F);
    check("4f_flags", {29'd0, frame_err, parity_err, overflow}, 32'd0);
    data_out_ready = 1'b1;
    drain("4f");

    // Back-to-back stream, consumer always ready.
    max_cnt = 0;
    rx0 = n_rx;
    for (int i = 0; i < 156; i++) send_frame(8'((i * 37 + 11) & 8'hFF), 1'b1);
    drain("stream");
    check("stream_rx", n_rx - rx0, 32'd156);
    check("stream_maxcount", max_cnt, 32'd1);
    check("stream_overflow", {31'd0, overflow}, 32'd0);

    // Overflow: DEPTH+1 frames, last one dropped.
    data_out_ready = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) send_frame(8'(8'hC0 + i), i < int'(DEPTH));
    repeat (2) @(negedge clk);
    check("ovf_count", {27'd0, count}, DEPTH);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    data_out_ready = 1'b1;
    drain("ovf");
    check("ovf_count_empty", {27'd0, count}, 32'd0);

    // Short glitch on the idle line.
    rx0 = n_rx;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_count", {27'd0, count}, 32'd0);
    check("glitch_rx", n_rx - rx0, 32'd0);
    check("glitch_flags", {29'd0, frame_err, parity_err, overflow}, 32'd0);

    // Bad stop bit, then line high for exactly CPB cycles before a good frame.
    send_body(8'h55);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    check("frm_err_set", {31'd0, frame_err}, 32'd1);
    check("frm_count", {27'd0, count}, 32'd0);
    serial_in = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h33, 1'b1);
    drain("after_frm");
    check("frm_err_sticky", {31'd0, frame_err}, 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("frm_err_cleared", {31'd0, frame_err}, 32'd0);

    // Reset in the middle of the data bits.
    rx0 = n_rx;
    serial_in = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'hA3, 1'b1);
    drain("rst_mid");
    check("rst_mid_rx", n_rx - rx0, 32'd1);
    check("rst_mid_flags", {29'd0, frame_err, parity_err, overflow}, 32'd0);

`ifdef UART_CAPTURE_PARITY_EN
    // 0x07 has three ones; even parity bit should be 1, send 0.
    data_out_ready = 1'b0;
    exp_q.push_back(8'h07);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      serial_in = (i < 3);
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    repeat (CPB) @(negedge clk);
    check("par_err", {31'd0, parity_err}, 32'd1);
    check("par_data", {24'd0, data_out}, 32'h07);
    check("par_count", {27'd0, count}, 32'd1);
    data_out_ready = 1'b1;
    drain("par");
`else
    check("par_tied_low", {31'd0, parity_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
